// File: rtl/crc5_r_pkg.sv
// Shared constants, state encoding and helpers for the token/handshake receiver.
package crc5_r_pkg;

    localparam logic [1:0] PID_TYPE_TOKEN     = 2'b01;
    localparam logic [1:0] PID_TYPE_HANDSHAKE = 2'b10;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;

    localparam logic [4:0] CRC5_INIT = 5'h1f;

    localparam logic [1:0] ERR_PID = 2'd0;
    localparam logic [1:0] ERR_CRC = 2'd1;
    localparam logic [1:0] ERR_LEN = 2'd2;
    localparam logic [1:0] ERR_SOP = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BYTE2,
        ST_BYTE3,
        ST_HOLD,
        ST_DRAIN
    } state_e;

    function automatic logic [4:0] rev5(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

endpackage

// File: rtl/crc5.sv
// Shared combinational CRC5 (x^5 + x^2 + 1) over 11 data bits, d[0] shifted in first.
module crc5 (
    input  logic [4:0]  c,
    input  logic [10:0] d,
    output logic [4:0]  c_out
);

    logic [4:0]  acc;
    logic [10:0] dsh;
    logic        fb;

    always_comb begin
        acc = c;
        dsh = d;
        fb  = 1'b0;
        for (int unsigned i = 0; i < 11; i++) begin
            fb  = acc[4] ^ dsh[0];
            acc = {acc[3:0], 1'b0} ^ {2'b00, fb, 1'b0, fb};
            dsh = dsh >> 1;
        end
        c_out = acc;
    end

endmodule

// File: rtl/crc5_r.sv
// Token/handshake receiver: PID check, ADDR/ENDP reassembly and CRC5 check.
// Optional address filter enabled by defining CRC5_R_ADDR_FILTER_EN (adds dev_addr).
module crc5_r
    import crc5_r_pkg::*;
#(
    parameter int STRICT_EOP  = 1,
    parameter int TOKEN_BYTES = 3
) (
    input  logic       clk,
    input  logic       rst,
`ifdef CRC5_R_ADDR_FILTER_EN
    input  logic [6:0] dev_addr,
`endif
    input  logic       rx_from_sop,
    input  logic       rx_from_eop,
    input  logic       rx_from_valid,
    output logic       rx_from_ready,
    input  logic [7:0] rx_from_data,
    output logic       rx_con_pid_en,
    output logic [3:0] rx_con_pid,
    output logic [3:0] rx_pid,
    output logic [6:0] rx_addr,
    output logic [3:0] rx_endp,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_err,
    output logic [1:0] rx_err_code
);

    // Only the 3-byte token layout is decodable; other lengths reject every token.
    localparam logic TOKEN_LEN_OK = (TOKEN_BYTES == 3);

    state_e     state_q, state_d;
    logic [3:0] pid_q, pid_d;
    logic [6:0] addr_q, addr_d;
    logic [3:0] endp_q, endp_d;
    logic       drain_q, drain_d;
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;
    logic       con_pid_en_q, con_pid_en_d;
    logic [3:0] con_pid_q, con_pid_d;

    logic       byte_xfer, link_xfer, pid_ok, crc_ok, addr_drop;
    logic [3:0] endp_rx;
    logic [4:0] crc_calc;

    assign byte_xfer = rx_from_valid && rx_from_ready;
    assign link_xfer = rx_valid && rx_ready;
    assign pid_ok    = (rx_from_data[7:4] == ~rx_from_data[3:0]);
    assign endp_rx   = {rx_from_data[2:0], endp_q[0]};

    crc5 u_crc5 (
        .c     (CRC5_INIT),
        .d     ({endp_rx, addr_q}),
        .c_out (crc_calc)
    );

    assign crc_ok = TOKEN_LEN_OK && (rev5(crc_calc) == rx_from_data[7:3]);

`ifdef CRC5_R_ADDR_FILTER_EN
    assign addr_drop = (addr_q != dev_addr) && (addr_q != '0);
`else
    assign addr_drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pid_q        <= '0;
            addr_q       <= '0;
            endp_q       <= '0;
            drain_q      <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
            con_pid_en_q <= 1'b0;
            con_pid_q    <= '0;
        end else begin
            pid_q        <= pid_d;
            addr_q       <= addr_d;
            endp_q       <= endp_d;
            drain_q      <= drain_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            con_pid_en_q <= con_pid_en_d;
            con_pid_q    <= con_pid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pid_d        = pid_q;
        addr_d       = addr_q;
        endp_d       = endp_q;
        drain_d      = drain_q;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        con_pid_en_d = 1'b0;
        con_pid_d    = con_pid_q;

        unique case (state_q)
            ST_BYTE2: if (byte_xfer && !rx_from_sop) begin
                addr_d    = rx_from_data[6:0];
                endp_d[0] = rx_from_data[7];
                if (rx_from_eop) begin
                    err_d = 1'b1; err_code_d = ERR_LEN; state_d = ST_IDLE;
                end else begin
                    state_d = ST_BYTE3;
                end
            end
            ST_BYTE3: if (byte_xfer && !rx_from_sop) begin
                endp_d = endp_rx;
                if (!crc_ok) begin
                    err_d = 1'b1; err_code_d = ERR_CRC;
                    state_d = rx_from_eop ? ST_IDLE : ST_DRAIN;
                end else if (addr_drop) begin
                    state_d = rx_from_eop ? ST_IDLE : ST_DRAIN;
                end else if (!rx_from_eop && (STRICT_EOP != 0)) begin
                    err_d = 1'b1; err_code_d = ERR_LEN; state_d = ST_DRAIN;
                end else begin
                    state_d = ST_HOLD;
                    drain_d = !rx_from_eop;
                end
            end
            ST_HOLD: if (link_xfer) begin
                state_d = drain_q ? ST_DRAIN : ST_IDLE;
                drain_d = 1'b0;
            end
            ST_DRAIN: if (byte_xfer && !rx_from_sop && rx_from_eop) begin
                state_d = ST_IDLE;
            end
            default: ;
        endcase

        // Any accepted SOP byte starts a new packet; mid-packet it also flags a restart,
        // though an error raised by the new PID byte itself takes the code slot.
        if (byte_xfer && rx_from_sop) begin
            drain_d = 1'b0;
            if (state_q != ST_IDLE) begin
                err_d = 1'b1; err_code_d = ERR_SOP;
            end
            if (!pid_ok) begin
                err_d = 1'b1; err_code_d = ERR_PID;
                state_d = rx_from_eop ? ST_IDLE : ST_DRAIN;
            end else begin
                pid_d        = rx_from_data[3:0];
                con_pid_en_d = 1'b1;
                con_pid_d    = rx_from_data[3:0];
                if (rx_from_data[1:0] == PID_TYPE_TOKEN) begin
                    if (rx_from_eop) begin
                        err_d = 1'b1; err_code_d = ERR_LEN; state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BYTE2;
                    end
                end else begin
                    addr_d = '0;
                    endp_d = '0;
                    if (rx_from_data[1:0] == PID_TYPE_HANDSHAKE) begin
                        if (rx_from_eop) begin
                            state_d = ST_HOLD;
                        end else begin
                            err_d = 1'b1; err_code_d = ERR_LEN; state_d = ST_DRAIN;
                        end
                    end else begin
                        state_d = rx_from_eop ? ST_IDLE : ST_DRAIN;
                    end
                end
            end
        end
    end

    always_comb begin
        rx_from_ready = (state_q != ST_HOLD);
        rx_valid      = (state_q == ST_HOLD);
    end

    assign rx_con_pid_en = con_pid_en_q;
    assign rx_con_pid    = con_pid_q;
    assign rx_pid        = pid_q;
    assign rx_addr       = addr_q;
    assign rx_endp       = endp_q;
    assign rx_err        = err_q;
    assign rx_err_code   = err_code_q;

endmodule

// File: tb/tb_crc5_r.sv
// Directed bench for crc5_r with hand-computed token CRCs; covers the address filter
// when CRC5_R_ADDR_FILTER_EN is defined.
module tb_crc5_r;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_from_sop, rx_from_eop, rx_from_valid, rx_from_ready;
    logic [7:0] rx_from_data;
    logic       rx_con_pid_en;
    logic [3:0] rx_con_pid, rx_pid, rx_endp;
    logic [6:0] rx_addr;
    logic       rx_valid, rx_ready, rx_err;
    logic [1:0] rx_err_code;
`ifdef CRC5_R_ADDR_FILTER_EN
    logic [6:0] dev_addr;
`endif

    always #5 clk = ~clk;

    crc5_r #(.STRICT_EOP(1), .TOKEN_BYTES(3)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef CRC5_R_ADDR_FILTER_EN
        .dev_addr      (dev_addr),
`endif
        .rx_from_sop   (rx_from_sop),
        .rx_from_eop   (rx_from_eop),
        .rx_from_valid (rx_from_valid),
        .rx_from_ready (rx_from_ready),
        .rx_from_data  (rx_from_data),
        .rx_con_pid_en (rx_con_pid_en),
        .rx_con_pid    (rx_con_pid),
        .rx_pid        (rx_pid),
        .rx_addr       (rx_addr),
        .rx_endp       (rx_endp),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_err        (rx_err),
        .rx_err_code   (rx_err_code)
    );

    int unsigned n_checks = 0, n_pass = 0;
    int unsigned err_cnt = 0, pid_cnt = 0, valid_cyc = 0;
    int unsigned e0, p0, v0;
    logic [1:0]  last_code = '0;

    // Pulse monitors sample mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_err) begin err_cnt++; last_code = rx_err_code; end
            if (rx_con_pid_en) pid_cnt++;
            if (rx_valid) valid_cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic sop, input logic eop, input logic [7:0] data);
        int unsigned waited = 0;
        rx_from_sop = sop; rx_from_eop = eop; rx_from_data = data; rx_from_valid = 1'b1;
        while (!rx_from_ready && waited < 20) begin step(); waited++; end
        if (!rx_from_ready) check("send_timeout", 0, 1);
        else step();
        rx_from_valid = 1'b0; rx_from_sop = 1'b0; rx_from_eop = 1'b0;
    endtask

    task automatic take(input string tag, input logic [3:0] pid, input logic [6:0] addr,
                        input logic [3:0] endp);
        check({tag, "_valid"}, rx_valid, 1);
        check({tag, "_pid"}, rx_pid, pid);
        check({tag, "_addr"}, rx_addr, addr);
        check({tag, "_endp"}, rx_endp, endp);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        check({tag, "_released"}, rx_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx_from_sop = 1'b0; rx_from_eop = 1'b0; rx_from_valid = 1'b0;
        rx_from_data = '0; rx_ready = 1'b0;
`ifdef CRC5_R_ADDR_FILTER_EN
        dev_addr = 7'h05;
`endif
        repeat (3) step();
        check("rst_ready", rx_from_ready, 1);
        check("rst_valid", rx_valid, 0);
        check("rst_err", rx_err, 0);
        check("rst_pid_en", rx_con_pid_en, 0);
        check("rst_fields", {rx_con_pid, rx_pid, rx_addr, rx_endp, rx_err_code}, 0);
        rst = 1'b0;
        step();

        // ACK handshake
        e0 = err_cnt; p0 = pid_cnt;
        send(1, 1, 8'hD2);
        check("ack_pid_en", rx_con_pid_en, 1);
        check("ack_con_pid", rx_con_pid, 4'h2);
        check("ack_hold_ready", rx_from_ready, 0);
        take("ack", 4'h2, 7'h00, 4'h0);
        check("ack_pid_en_once", pid_cnt, p0 + 1);
        check("ack_no_err", err_cnt, e0);

        // SETUP addr 05 endp 3 with link stalled four cycles
        e0 = err_cnt;
        send(1, 0, 8'h2D);
        check("setup_pid_en", rx_con_pid_en, 1);
        send(0, 0, 8'h85);
        check("setup_not_yet", rx_valid, 0);
        send(0, 1, 8'hB1);
        check("setup_latency", rx_valid, 1);
        repeat (4) step();
        check("setup_stall_ready", rx_from_ready, 0);
        take("setup", 4'hD, 7'h05, 4'h3);
        check("setup_no_err", err_cnt, e0);

        // Same token with a corrupted CRC bit
        e0 = err_cnt; v0 = valid_cyc;
        send(1, 0, 8'h2D); send(0, 0, 8'h85); send(0, 1, 8'hF1);
        step();
        check("badcrc_err", err_cnt, e0 + 1);
        check("badcrc_code", last_code, 2'd1);
        check("badcrc_no_valid", valid_cyc, v0);

        // Bad PID complement, two trailing bytes drained, then ACK
        e0 = err_cnt; p0 = pid_cnt;
        send(1, 0, 8'h12); send(0, 0, 8'h34); send(0, 1, 8'h56);
        step();
        check("badpid_err", err_cnt, e0 + 1);
        check("badpid_code", last_code, 2'd0);
        check("badpid_no_pid_en", pid_cnt, p0);
        check("badpid_ready", rx_from_ready, 1);
        send(1, 1, 8'hD2);
        take("ack_after_drain", 4'h2, 7'h00, 4'h0);
        check("ack_after_drain_err", err_cnt, e0 + 1);

        // SOP restart inside a token
        e0 = err_cnt;
        send(1, 0, 8'h2D); send(1, 1, 8'hD2);
        take("restart_ack", 4'h2, 7'h00, 4'h0);
        check("restart_err", err_cnt, e0 + 1);
        check("restart_code", last_code, 2'd3);

        // Length errors: EOP on token PID, handshake without EOP, missing EOP on byte 3
        e0 = err_cnt; v0 = valid_cyc;
        send(1, 1, 8'h2D);
        step();
        check("len_tok_pid", err_cnt, e0 + 1);
        check("len_tok_pid_code", last_code, 2'd2);
        send(1, 0, 8'hD2); send(0, 1, 8'h00);
        step();
        check("len_hs", err_cnt, e0 + 2);
        send(1, 0, 8'h2D); send(0, 0, 8'h85); send(0, 0, 8'hB1); send(0, 1, 8'h00);
        step();
        check("len_strict", err_cnt, e0 + 3);
        check("len_strict_code", last_code, 2'd2);
        check("len_no_valid", valid_cyc, v0);

        // DATA0 PID: reported to link_control only
        v0 = valid_cyc;
        send(1, 1, 8'hC3);
        check("data_pid_en", rx_con_pid_en, 1);
        check("data_con_pid", rx_con_pid, 4'h3);
        step();
        check("data_no_valid", valid_cyc, v0);
        check("data_addr_cleared", rx_addr, 0);

`ifdef CRC5_R_ADDR_FILTER_EN
        // OUT tokens: addr 06 dropped, addr 05 and 00 delivered
        e0 = err_cnt; v0 = valid_cyc; p0 = pid_cnt;
        send(1, 0, 8'hE1); send(0, 0, 8'h86); send(0, 1, 8'hF1);
        step();
        check("filt_drop_valid", valid_cyc, v0);
        check("filt_drop_err", err_cnt, e0);
        check("filt_drop_pid_en", pid_cnt, p0 + 1);
        send(1, 0, 8'hE1); send(0, 0, 8'h85); send(0, 1, 8'hB1);
        take("filt_match", 4'h1, 7'h05, 4'h3);
        send(1, 0, 8'hE1); send(0, 0, 8'h80); send(0, 1, 8'h71);
        take("filt_zero", 4'h1, 7'h00, 4'h3);
        check("filt_err", err_cnt, e0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
